// File: rtl/ps2_rx_buffer_pkg.sv
// Shared definitions for the PS/2 receive path: FSM encoding, protocol
// constants and the frame validation helper.
package ps2_rx_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FR_VALID      = 2'd0,
    FR_PARITY_ERR = 2'd1,
    FR_FRAME_ERR  = 2'd2
  } frame_status_t;

  localparam logic [7:0] BREAK  = 8'hF0;
  localparam logic [7:0] EXTEND = 8'hE0;

  localparam int FILTER_CNT_W = 4;

  // A bad stop bit outranks a parity error; parity is odd over data + parity.
  function automatic frame_status_t check_frame(
    input logic [7:0] data,
    input logic       parity,
    input logic       stop
  );
    if (!stop)
      return FR_FRAME_ERR;
    else if (^{data, parity})
      return FR_VALID;
    else
      return FR_PARITY_ERR;
  endfunction

endpackage

// File: rtl/ps2_rx_buffer_filter.sv
// Input conditioning for the PS/2 lines: 2-flop synchronizers, a saturating
// glitch filter on the clock line and a falling-edge strobe.
module ps2_filter
  import ps2_rx_buffer_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic PS2_CLK,
  input  logic PS2_DATA,
  output logic data,
  output logic fall
);

  localparam int FILTER_LAST_INT = (FILTER_LEN > 16) ? 15 :
                                   (FILTER_LEN < 1)  ? 0  : FILTER_LEN - 1;
  localparam logic [FILTER_CNT_W-1:0] FILTER_LAST = FILTER_CNT_W'(FILTER_LAST_INT);
  localparam logic [FILTER_CNT_W-1:0] FILTER_MAX  = '1;

  logic [1:0]              clk_sync_reg;
  logic [1:0]              data_sync_reg;
  logic                    clk_filt_reg;
  logic [FILTER_CNT_W-1:0] filt_cnt_reg;
  logic                    fall_reg;

  // The counter tracks how many consecutive samples disagree with the
  // accepted level; any agreeing sample restarts it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      clk_filt_reg  <= 1'b1;
      filt_cnt_reg  <= '0;
      fall_reg      <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], PS2_CLK};
      data_sync_reg <= {data_sync_reg[0], PS2_DATA};
      fall_reg      <= 1'b0;
      if (clk_sync_reg[1] == clk_filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg >= FILTER_LAST) begin
        clk_filt_reg <= clk_sync_reg[1];
        filt_cnt_reg <= '0;
        fall_reg     <= ~clk_sync_reg[1];
      end else if (filt_cnt_reg != FILTER_MAX) begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  assign data = data_sync_reg[1];
  assign fall = fall_reg;

endmodule

// File: rtl/ps2_rx_buffer.sv
// PS/2 keyboard receiver: frames 11-bit PS/2 packets and keeps the last two
// valid bytes for the keyboard controller.
module ps2_rx_buffer
  import ps2_rx_buffer_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic [15:0] KBBuffer,
  output logic        Rx_Done,
  output logic        Parity_Err,
  output logic        Frame_Err
);

  localparam int TO_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_LAST_INT = (TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LAST_INT);

  logic data;
  logic fall;

  ps2_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .CLK      (CLK),
    .RESET    (RESET),
    .PS2_CLK  (PS2_CLK),
    .PS2_DATA (PS2_DATA),
    .data     (data),
    .fall     (fall)
  );

  state_t          state_reg;
  logic [2:0]      bit_cnt_reg;
  logic [7:0]      shift_reg;
  logic            parity_reg;
  logic [TO_W-1:0] to_cnt_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      to_cnt_reg  <= '0;
      KBBuffer    <= '0;
      Rx_Done     <= 1'b0;
      Parity_Err  <= 1'b0;
      Frame_Err   <= 1'b0;
    end else begin
      Rx_Done    <= 1'b0;
      Parity_Err <= 1'b0;
      Frame_Err  <= 1'b0;

      // A stalled keyboard must not leave the receiver stuck mid-frame.
      if (state_reg == ST_IDLE || fall) begin
        to_cnt_reg <= '0;
      end else if (to_cnt_reg == TO_LAST) begin
        to_cnt_reg  <= '0;
        state_reg   <= ST_IDLE;
        bit_cnt_reg <= '0;
        shift_reg   <= '0;
        Frame_Err   <= 1'b1;
      end else begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end

      if (fall) begin
        case (state_reg)
          ST_IDLE: begin
            if (!data) begin
              state_reg   <= ST_DATA;
              bit_cnt_reg <= '0;
            end
          end
          ST_DATA: begin
            shift_reg   <= {data, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7)
              state_reg <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_reg <= data;
            state_reg  <= ST_STOP;
          end
          ST_STOP: begin
            state_reg <= ST_IDLE;
            case (check_frame(shift_reg, parity_reg, data))
              FR_VALID: begin
                KBBuffer <= {KBBuffer[7:0], shift_reg};
                Rx_Done  <= 1'b1;
              end
              FR_PARITY_ERR: Parity_Err <= 1'b1;
              default:       Frame_Err  <= 1'b1;
            endcase
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_buffer.sv
// Self-checking bench for ps2_rx_buffer: vector table, randomized frames
// against a byte-level model, and hand-written glitch/timeout/reset cases.
module tb_ps2_rx_buffer;
  import ps2_rx_buffer_pkg::*;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int HALF           = 40;   // PS/2 half period in CLK cycles (scaled)

  logic        clk = 1'b0;
  logic        RESET;
  logic        PS2_CLK;
  logic        PS2_DATA;
  logic [15:0] KBBuffer;
  logic        Rx_Done;
  logic        Parity_Err;
  logic        Frame_Err;

  ps2_rx_buffer #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .CLK        (clk),
    .RESET      (RESET),
    .PS2_CLK    (PS2_CLK),
    .PS2_DATA   (PS2_DATA),
    .KBBuffer   (KBBuffer),
    .Rx_Done    (Rx_Done),
    .Parity_Err (Parity_Err),
    .Frame_Err  (Frame_Err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0, perr_cnt = 0, ferr_cnt = 0;
  logic [15:0] kb_at_done = '0;
  bit prev_rx = 0, prev_perr = 0, prev_ferr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitor: counts events, enforces one-cycle width and exclusivity.
  always @(negedge clk) begin
    if (!RESET) begin
      int sum;
      sum = int'(Rx_Done) + int'(Parity_Err) + int'(Frame_Err);
      if (sum > 0) check("pulses_exclusive", sum, 1);
      if (Rx_Done) begin
        rx_cnt++;
        kb_at_done = KBBuffer;
        check("rx_done_width", prev_rx, 0);
      end
      if (Parity_Err) begin
        perr_cnt++;
        check("parity_err_width", prev_perr, 0);
      end
      if (Frame_Err) begin
        ferr_cnt++;
        check("frame_err_width", prev_ferr, 0);
      end
    end
    prev_rx   = Rx_Done;
    prev_perr = Parity_Err;
    prev_ferr = Frame_Err;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic v);
    PS2_DATA = v;
    wait_cycles(HALF);
    PS2_CLK = 1'b0;
    wait_cycles(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(data[i]);
    ps2_bit(par);
    ps2_bit(stop);
    PS2_DATA = 1'b1;
    wait_cycles(3 * HALF);
  endtask

  function automatic logic good_parity(input logic [7:0] data);
    return ($countones(data) % 2) == 0;
  endfunction

  typedef struct {
    logic [7:0]  data;
    bit          bad_par;
    bit          stop;
    logic [15:0] exp_kb;
    int          exp_rx;
    int          exp_perr;
    int          exp_ferr;
  } vec_t;

  vec_t vecs[8];
  logic [15:0] kb_model;

  initial begin
    int r0, p0, f0;
    vecs[0] = '{8'h1C,  0, 1, 16'h001C, 1, 0, 0};
    vecs[1] = '{BREAK,  0, 1, 16'h1CF0, 1, 0, 0};
    vecs[2] = '{8'h1C,  0, 1, 16'hF01C, 1, 0, 0};
    vecs[3] = '{8'h1C,  1, 1, 16'hF01C, 0, 1, 0};
    vecs[4] = '{8'h1C,  0, 0, 16'hF01C, 0, 0, 1};
    vecs[5] = '{8'h1C,  0, 1, 16'h1C1C, 1, 0, 0};
    vecs[6] = '{EXTEND, 0, 1, 16'h1CE0, 1, 0, 0};
    vecs[7] = '{8'h45,  0, 1, 16'hE045, 1, 0, 0};

    RESET = 1'b1;
    PS2_CLK = 1'b1;
    PS2_DATA = 1'b1;
    wait_cycles(5);
    check("reset_kb", KBBuffer, 16'h0000);
    check("reset_rx_done", Rx_Done, 0);
    check("reset_parity_err", Parity_Err, 0);
    check("reset_frame_err", Frame_Err, 0);
    RESET = 1'b0;
    wait_cycles(20);

    for (int i = 0; i < 8; i++) begin
      logic par;
      r0 = rx_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      par = good_parity(vecs[i].data) ^ vecs[i].bad_par;
      send_frame(vecs[i].data, par, vecs[i].stop);
      check($sformatf("vec%0d_kb", i), KBBuffer, vecs[i].exp_kb);
      check($sformatf("vec%0d_rx", i), rx_cnt - r0, vecs[i].exp_rx);
      check($sformatf("vec%0d_perr", i), perr_cnt - p0, vecs[i].exp_perr);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      if (vecs[i].exp_rx == 1)
        check($sformatf("vec%0d_kb_at_done", i), kb_at_done, vecs[i].exp_kb);
    end

    // Randomized frames; expected outcome from the frame rules alone.
    kb_model = 16'hE045;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic par, stop;
      int kind, ones;
      bit valid;
      d    = 8'($urandom);
      kind = $urandom_range(0, 7);
      par  = good_parity(d) ^ (kind == 0);
      stop = (kind != 1);
      ones = $countones(d) + int'(par);
      valid = stop && (ones % 2 == 1);
      if (valid) kb_model = {kb_model[7:0], d};
      r0 = rx_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(d, par, stop);
      check($sformatf("rnd%0d_kb", n), KBBuffer, kb_model);
      check($sformatf("rnd%0d_rx", n), rx_cnt - r0, valid ? 1 : 0);
      check($sformatf("rnd%0d_perr", n), perr_cnt - p0, (stop && !valid) ? 1 : 0);
      check($sformatf("rnd%0d_ferr", n), ferr_cnt - f0, stop ? 0 : 1);
    end

    // Short low glitch on PS2_CLK with data low: must not look like a start bit.
    r0 = rx_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    PS2_DATA = 1'b0;
    wait_cycles(10);
    PS2_CLK = 1'b0;
    wait_cycles(3);
    PS2_CLK = 1'b1;
    wait_cycles(50);
    PS2_DATA = 1'b1;
    wait_cycles(50);
    check("glitch_no_events", (rx_cnt - r0) + (perr_cnt - p0) + (ferr_cnt - f0), 0);
    send_frame(8'h5A, good_parity(8'h5A), 1'b1);
    kb_model = {kb_model[7:0], 8'h5A};
    check("glitch_next_frame_kb", KBBuffer, kb_model);

    // Partial frame followed by silence.
    r0 = rx_cnt; f0 = ferr_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    PS2_DATA = 1'b1;
    wait_cycles(TIMEOUT_CYCLES / 2);
    check("timeout_not_early", ferr_cnt - f0, 0);
    wait_cycles(TIMEOUT_CYCLES);
    check("timeout_frame_err", ferr_cnt - f0, 1);
    check("timeout_no_rx", rx_cnt - r0, 0);
    check("timeout_kb_held", KBBuffer, kb_model);
    send_frame(8'h45, good_parity(8'h45), 1'b1);
    check("timeout_next_frame", KBBuffer[7:0], 8'h45);

    // Reset after 5 data bits of F0; the remaining bits are all ones.
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(BREAK[i]);
    RESET = 1'b1;
    #1;
    check("midreset_kb", KBBuffer, 16'h0000);
    check("midreset_rx", Rx_Done, 0);
    check("midreset_perr", Parity_Err, 0);
    check("midreset_ferr", Frame_Err, 0);
    wait_cycles(5);
    RESET = 1'b0;
    r0 = rx_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    for (int i = 5; i < 8; i++) ps2_bit(BREAK[i]);
    ps2_bit(good_parity(BREAK));
    ps2_bit(1'b1);
    wait_cycles(3 * HALF);
    check("midreset_ignored", (rx_cnt - r0) + (perr_cnt - p0) + (ferr_cnt - f0), 0);
    check("midreset_kb_after", KBBuffer, 16'h0000);
    send_frame(8'h1C, good_parity(8'h1C), 1'b1);
    check("midreset_fresh_frame", KBBuffer, 16'h001C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
